// File: rtl/video_timing_recover.sv
// Rebuilds pixel coordinates from a de/hsync/vsync stream and
// tracks lock against nominal line and frame timing.
module video_timing_recover #(
  parameter int H_ACTIVE_PIXEL = 640,
  parameter int H_TOTAL        = 800,
  parameter int V_ACTIVE_LINE  = 480,
  parameter int V_TOTAL        = 525,
  parameter int LOCK_FRAMES    = 2,
  localparam int HW = $clog2(H_TOTAL),
  localparam int VW = $clog2(V_TOTAL),
  localparam int GW = $clog2(LOCK_FRAMES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_de,
  input  logic          in_hsync,
  input  logic          in_vsync,
  output logic [HW-1:0] out_hcnt,
  output logic [VW-1:0] out_vcnt,
  output logic          out_de,
  output logic          out_line_start,
  output logic          out_frame_start,
  output logic          out_locked,
  output logic          out_err
);

  typedef enum logic [1:0] {
    SEARCH,
    CHECK,
    LOCKED
  } state_t;

  state_t state_q, state_d;

  logic de1, hs1, vs1;
  logic de2, hs2, vs2;
  logic de_rise, de_fall, hs_rise, vs_rise;
  logic first_line;

  logic          armed_q, armed_d;
  logic [HW:0]   lcnt_q, lcnt_d;
  logic [VW:0]   nde_q, nde_d;
  logic [VW:0]   nhs_q, nhs_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [HW-1:0] hcnt_d;
  logic [VW-1:0] vcnt_d;
  logic          line_err, frame_err, err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {de1, hs1, vs1} <= 3'b000;
      {de2, hs2, vs2} <= 3'b000;
    end else begin
      {de1, hs1, vs1} <= {in_de, in_hsync, in_vsync};
      {de2, hs2, vs2} <= {de1, hs1, vs1};
    end
  end

  assign de_rise = de1 & ~de2;
  assign de_fall = ~de1 & de2;
  assign hs_rise = hs1 & ~hs2;
  assign vs_rise = vs1 & ~vs2;
  // vsync is handled before a coincident de rise
  assign first_line = armed_q | vs_rise;

  always_comb begin
    hcnt_d = out_hcnt;
    if (de_rise) begin
      hcnt_d = '0;
    end else if (de1 && out_hcnt != HW'(H_TOTAL - 1)) begin
      hcnt_d = out_hcnt + 1'b1;
    end

    vcnt_d  = out_vcnt;
    armed_d = armed_q | vs_rise;
    if (de_rise) begin
      if (first_line) begin
        vcnt_d  = '0;
        armed_d = 1'b0;
      end else if (out_vcnt != VW'(V_TOTAL - 1)) begin
        vcnt_d = out_vcnt + 1'b1;
      end
    end

    lcnt_d = lcnt_q;
    if (de_rise) begin
      lcnt_d = (HW+1)'(1);
    end else if (lcnt_q != '1) begin
      lcnt_d = lcnt_q + 1'b1;
    end

    nde_d = nde_q;
    if (vs_rise) begin
      nde_d = (VW+1)'(de_rise);
    end else if (de_rise && nde_q != '1) begin
      nde_d = nde_q + 1'b1;
    end

    nhs_d = nhs_q;
    if (vs_rise) begin
      nhs_d = (VW+1)'(hs_rise);
    end else if (hs_rise && nhs_q != '1) begin
      nhs_d = nhs_q + 1'b1;
    end
  end

  always_comb begin
    line_err =
      (de_fall && out_hcnt != HW'(H_ACTIVE_PIXEL - 1)) ||
      (de_rise && !first_line &&
       lcnt_q != (HW+1)'(H_TOTAL)) ||
      (de1 && vs1);
    frame_err = vs_rise &&
      (nde_q != (VW+1)'(V_ACTIVE_LINE) ||
       nhs_q != (VW+1)'(V_TOTAL));
    err = (state_q != SEARCH) && (line_err || frame_err);
  end

  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    unique case (state_q)
      SEARCH: begin
        if (vs_rise) begin
          state_d = CHECK;
          gcnt_d  = '0;
        end
      end
      CHECK: begin
        if (err) begin
          state_d = SEARCH;
          gcnt_d  = '0;
        end else if (vs_rise) begin
          gcnt_d = gcnt_q + 1'b1;
          if (gcnt_q == GW'(LOCK_FRAMES - 1)) begin
            state_d = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (err) begin
          state_d = SEARCH;
          gcnt_d  = '0;
        end
      end
      default: begin
        state_d = SEARCH;
        gcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEARCH;
      gcnt_q  <= '0;
      armed_q <= 1'b0;
      lcnt_q  <= '0;
      nde_q   <= '0;
      nhs_q   <= '0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      armed_q <= armed_d;
      lcnt_q  <= lcnt_d;
      nde_q   <= nde_d;
      nhs_q   <= nhs_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_hcnt        <= '0;
      out_vcnt        <= '0;
      out_de          <= 1'b0;
      out_line_start  <= 1'b0;
      out_frame_start <= 1'b0;
      out_locked      <= 1'b0;
      out_err         <= 1'b0;
    end else begin
      out_hcnt        <= hcnt_d;
      out_vcnt        <= vcnt_d;
      out_de          <= de1;
      out_line_start  <= de_rise && state_d == LOCKED;
      out_frame_start <= de_rise && first_line &&
                         state_d == LOCKED;
      out_locked      <= state_d == LOCKED;
      out_err         <= err;
    end
  end

endmodule

// File: tb/tb_video_timing_recover.sv
// Directed bench for video_timing_recover on a scaled-down
// 8x4 active / 12x7 total raster.
module tb_video_timing_recover;

  localparam int HA = 8;
  localparam int HT = 12;
  localparam int VA = 4;
  localparam int VT = 7;
  localparam int LF = 2;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);

  // fault injection points (frame numbers)
  localparam int SHORT_F = 4;
  localparam int EXTRA_F = 7;
  localparam int DEVS_F  = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_de, in_hsync, in_vsync;
  logic [HW-1:0] out_hcnt;
  logic [VW-1:0] out_vcnt;
  logic          out_de;
  logic          out_line_start;
  logic          out_frame_start;
  logic          out_locked;
  logic          out_err;

  int n_chk   = 0;
  int n_fail  = 0;
  int err_cnt = 0;
  int si      = 0;
  int e0;

  video_timing_recover #(
    .H_ACTIVE_PIXEL(HA),
    .H_TOTAL(HT),
    .V_ACTIVE_LINE(VA),
    .V_TOTAL(VT),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_de(in_de),
    .in_hsync(in_hsync),
    .in_vsync(in_vsync),
    .out_hcnt(out_hcnt),
    .out_vcnt(out_vcnt),
    .out_de(out_de),
    .out_line_start(out_line_start),
    .out_frame_start(out_frame_start),
    .out_locked(out_locked),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  function automatic int idx(int f, int l, int x);
    return (f * VT + l) * HT + x;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  // drive stream position si for one clock
  task automatic tick();
    int f, l, x;
    f = si / (VT * HT);
    l = (si / HT) % VT;
    x = si % HT;
    @(posedge clk);
    #1;
    if (out_err === 1'b1) err_cnt++;
    in_de = ((l < VA) && (x < HA) &&
             !(f == SHORT_F && l == 1 && x == HA - 1)) ||
            (f == DEVS_F && l == 5 && x == 3);
    in_hsync = (x == 9 || x == 10) ||
               (f == EXTRA_F && l == 2 && (x == 4 || x == 5));
    in_vsync = (l == 5);
    si++;
  endtask

  // advance until outputs reflect input position t
  task automatic wait_obs(int t);
    while (si - 3 < t) tick();
  endtask

  initial begin
    rst      = 1'b1;
    in_de    = 1'b0;
    in_hsync = 1'b0;
    in_vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hcnt", out_hcnt, 0);
    chk("rst_vcnt", out_vcnt, 0);
    chk("rst_de", out_de, 0);
    chk("rst_locked", out_locked, 0);
    chk("rst_err", out_err, 0);
    chk("rst_fs", out_frame_start, 0);
    rst = 1'b0;

    // initial lock at third vsync rising
    wait_obs(idx(1, 5, 0));
    chk("lock_f1", out_locked, 0);
    wait_obs(idx(2, 5, 0) - 1);
    chk("lock_pre", out_locked, 0);
    wait_obs(idx(2, 5, 0));
    chk("lock_rise", out_locked, 1);

    wait_obs(idx(3, 0, 0));
    chk("fs_pulse", out_frame_start, 1);
    chk("fs_ls", out_line_start, 1);
    chk("fs_hcnt", out_hcnt, 0);
    chk("fs_vcnt", out_vcnt, 0);
    chk("fs_de", out_de, 1);
    chk("no_err_nom", err_cnt, 0);
    wait_obs(idx(3, 0, 1));
    chk("fs_one_cycle", out_frame_start, 0);
    chk("hcnt_inc", out_hcnt, 1);

    wait_obs(idx(3, 1, 0));
    chk("l1_fs", out_frame_start, 0);
    chk("l1_ls", out_line_start, 1);
    chk("l1_vcnt", out_vcnt, 1);
    wait_obs(idx(3, 2, 0));
    chk("l2_ls", out_line_start, 1);
    wait_obs(idx(3, 2, 11));
    chk("l2_ls_gap", out_line_start, 0);
    wait_obs(idx(3, 3, 0));
    chk("l3_ls", out_line_start, 1);
    wait_obs(idx(3, 3, 7));
    chk("last_hcnt", out_hcnt, HA - 1);
    chk("last_vcnt", out_vcnt, VA - 1);
    chk("last_de", out_de, 1);
    wait_obs(idx(3, 3, 10));
    chk("hold_hcnt", out_hcnt, HA - 1);
    chk("hold_de", out_de, 0);

    // one line with de one cycle short
    wait_obs(idx(SHORT_F, 1, 6));
    chk("short_pre_err", out_err, 0);
    chk("short_pre_lock", out_locked, 1);
    wait_obs(idx(SHORT_F, 1, 7));
    chk("short_err", out_err, 1);
    chk("short_unlock", out_locked, 0);
    wait_obs(idx(SHORT_F, 1, 8));
    chk("short_single", out_err, 0);
    wait_obs(idx(6, 5, 0) - 1);
    chk("relock_pre", out_locked, 0);
    wait_obs(idx(6, 5, 0));
    chk("relock", out_locked, 1);
    chk("short_errcnt", err_cnt, 1);

    // one extra hsync pulse in a frame
    wait_obs(idx(EXTRA_F, 4, 11));
    chk("extra_no_line_err", err_cnt, 1);
    chk("extra_pre_lock", out_locked, 1);
    wait_obs(idx(EXTRA_F, 5, 0));
    chk("extra_err", out_err, 1);
    chk("extra_unlock", out_locked, 0);

    // de high during vsync while in CHECK
    wait_obs(idx(DEVS_F, 5, 2));
    chk("devs_pre_cnt", err_cnt, 2);
    wait_obs(idx(DEVS_F, 5, 3));
    chk("devs_err", out_err, 1);
    wait_obs(idx(DEVS_F, 5, 4));
    chk("devs_single", out_err, 0);
    wait_obs(idx(11, 5, 0));
    chk("devs_gcnt_clr", out_locked, 0);
    wait_obs(idx(12, 5, 0));
    chk("devs_relock", out_locked, 1);

    // reset mid-frame while locked
    wait_obs(idx(13, 2, 3));
    chk("prerst_lock", out_locked, 1);
    e0 = err_cnt;
    rst = 1'b1;
    #1;
    chk("mrst_hcnt", out_hcnt, 0);
    chk("mrst_vcnt", out_vcnt, 0);
    chk("mrst_de", out_de, 0);
    chk("mrst_lock", out_locked, 0);
    chk("mrst_ls", out_line_start, 0);
    repeat (3) tick();
    chk("mrst_hold_hcnt", out_hcnt, 0);
    chk("mrst_hold_lock", out_locked, 0);
    rst = 1'b0;
    wait_obs(idx(14, 5, 0));
    chk("post_f14", out_locked, 0);
    wait_obs(idx(15, 5, 0) - 1);
    chk("post_pre", out_locked, 0);
    wait_obs(idx(15, 5, 0));
    chk("post_relock", out_locked, 1);
    chk("post_no_err", err_cnt, e0);
    chk("total_err", err_cnt, 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
